// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern and shifts it out MSB-first,
// optionally repeating it back-to-back, with registered valid/busy/done handshakes.
module seq_pattern_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned REP_WIDTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] pattern_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [REP_WIDTH-1:0]  repeat_in,
  output logic                  seq_out,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pat_q, pat_d;
  logic [LEN_WIDTH-1:0]    last_q, last_d;
  logic [LEN_WIDTH-1:0]    bit_q, bit_d;
  logic [REP_WIDTH-1:0]    pass_q, pass_d;
  logic                    seq_q, seq_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [LEN_WIDTH-1:0]    eff_last_c;

  // Index of the first bit to send; out-of-range lengths select the full pattern.
  always_comb begin
    if ((len_in == '0) || (len_in > LEN_MAX)) begin
      eff_last_c = LEN_MAX - LEN_WIDTH'(1);
    end else begin
      eff_last_c = len_in - LEN_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    last_d  = last_q;
    bit_d   = bit_q;
    pass_d  = pass_q;
    seq_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d = SEND;
          pat_d   = pattern_in;
          last_d  = eff_last_c;
          bit_d   = eff_last_c;
          pass_d  = repeat_in;
          seq_d   = pattern_in[IDX_W'(eff_last_c)];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (bit_q != '0) begin
          bit_d   = bit_q - LEN_WIDTH'(1);
          seq_d   = pat_q[IDX_W'(bit_q - LEN_WIDTH'(1))];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (pass_q != '0) begin
          // Wrap to the top of the pattern with no idle cycle between passes.
          pass_d  = pass_q - REP_WIDTH'(1);
          bit_d   = last_q;
          seq_d   = pat_q[IDX_W'(last_q)];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      pat_q   <= '0;
      last_q  <= '0;
      bit_q   <= '0;
      pass_q  <= '0;
      seq_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      pass_q  <= pass_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq_out   = seq_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a transfer table plus hand-written corner sequences.
module tb_seq_pattern_tx;

  logic       clk_in;
  logic       reset_in;
  logic       start_in;
  logic [7:0] pattern_in;
  logic [3:0] len_in;
  logic [3:0] repeat_in;
  logic       seq_out;
  logic       valid_out;
  logic       busy_out;
  logic       done_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  rep;
    logic [31:0] exp_s;
    int          n;
    bit          noisy;
  } vec_t;

  vec_t vecs[8];

  seq_pattern_tx #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (4),
    .REP_WIDTH (4)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .start_in  (start_in),
    .pattern_in(pattern_in),
    .len_in    (len_in),
    .repeat_in (repeat_in),
    .seq_out   (seq_out),
    .valid_out (valid_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Compare {seq, valid, busy, done} against the expected nibble.
  task automatic chk_out(input string name, input logic [3:0] exp_v);
    logic [3:0] act;
    act = {seq_out, valid_out, busy_out, done_out};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: {seq,valid,busy,done} got %b expected %b", name, act, exp_v);
    end
  endtask

  // Start a transfer and check every bit plus the done cycle; returns in the DONE cycle.
  task automatic run_xfer(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep,
                          input logic [31:0] exp_s, input int n, input bit noisy,
                          input string tag);
    start_in   = 1'b1;
    pattern_in = pat;
    len_in     = len;
    repeat_in  = rep;
    step();
    start_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_out($sformatf("%s bit%0d", tag, i), {exp_s[n-1-i], 3'b110});
      if (noisy) begin
        start_in   = 1'($urandom_range(0, 1));
        pattern_in = 8'($urandom);
        len_in     = 4'($urandom);
        repeat_in  = 4'($urandom);
      end
      step();
    end
    start_in   = 1'b0;
    pattern_in = 8'h00;
    len_in     = 4'd0;
    repeat_in  = 4'd0;
    chk_out($sformatf("%s done", tag), 4'b0001);
  endtask

  initial begin
    vecs[0] = '{pat: 8'b0000_0110, len: 4'd3,  rep: 4'd0,  exp_s: 32'b110,       n: 3,  noisy: 1'b0};
    vecs[1] = '{pat: 8'hA5,        len: 4'd8,  rep: 4'd2,  exp_s: 32'hA5A5A5,    n: 24, noisy: 1'b1};
    vecs[2] = '{pat: 8'hA5,        len: 4'd0,  rep: 4'd0,  exp_s: 32'hA5,        n: 8,  noisy: 1'b0};
    vecs[3] = '{pat: 8'h3C,        len: 4'd12, rep: 4'd0,  exp_s: 32'h3C,        n: 8,  noisy: 1'b0};
    vecs[4] = '{pat: 8'h01,        len: 4'd1,  rep: 4'd0,  exp_s: 32'b1,         n: 1,  noisy: 1'b0};
    vecs[5] = '{pat: 8'hC3,        len: 4'd4,  rep: 4'd1,  exp_s: 32'b00110011,  n: 8,  noisy: 1'b1};
    vecs[6] = '{pat: 8'hFE,        len: 4'd1,  rep: 4'd3,  exp_s: 32'b0000,      n: 4,  noisy: 1'b0};
    vecs[7] = '{pat: 8'h81,        len: 4'd2,  rep: 4'd15, exp_s: 32'h55555555,  n: 32, noisy: 1'b1};

    reset_in   = 1'b1;
    start_in   = 1'b0;
    pattern_in = 8'h00;
    len_in     = 4'd0;
    repeat_in  = 4'd0;
    step();
    step();
    chk_out("reset state", 4'b0000);
    reset_in = 1'b0;
    step();
    chk_out("idle after reset", 4'b0000);

    // Reset and start together: reset wins and the block stays idle.
    reset_in   = 1'b1;
    start_in   = 1'b1;
    pattern_in = 8'hFF;
    len_in     = 4'd8;
    step();
    chk_out("reset+start", 4'b0000);
    reset_in = 1'b0;
    start_in = 1'b0;
    step();
    chk_out("reset+start idle", 4'b0000);

    foreach (vecs[v]) begin
      run_xfer(vecs[v].pat, vecs[v].len, vecs[v].rep, vecs[v].exp_s, vecs[v].n,
               vecs[v].noisy, $sformatf("vec%0d", v));
      step();
      chk_out($sformatf("vec%0d idle1", v), 4'b0000);
      step();
      chk_out($sformatf("vec%0d idle2", v), 4'b0000);
    end

    // Start sampled in the DONE cycle: back-to-back with exactly one gap cycle.
    run_xfer(8'b0000_0110, 4'd3, 4'd0, 32'b110, 3, 1'b0, "b2b first");
    run_xfer(8'hA5, 4'd4, 4'd0, 32'b0101, 4, 1'b0, "b2b second");
    step();
    chk_out("b2b idle", 4'b0000);

    // Reset on the 4th bit of an 8-bit send aborts without a done pulse.
    start_in   = 1'b1;
    pattern_in = 8'hA5;
    len_in     = 4'd8;
    repeat_in  = 4'd0;
    step();
    start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("abort bit%0d", i), (i % 2 == 0) ? 4'b1110 : 4'b0110);
      step();
    end
    chk_out("abort bit3", 4'b0110);
    reset_in = 1'b1;
    step();
    chk_out("abort reset", 4'b0000);
    reset_in = 1'b0;
    step();
    chk_out("abort no done", 4'b0000);
    step();
    chk_out("abort idle", 4'b0000);
    run_xfer(8'b0000_0110, 4'd3, 4'd0, 32'b110, 3, 1'b0, "post-abort");
    step();
    chk_out("post-abort idle", 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
